// File: rtl/multichannel_staticisor.sv
// Multi-word staticisor: CHANNELS staging words loaded serially (LSB first, index 0) or in parallel,
// copied to the static outputs on the present phase. One present edge to output; no backpressure, ready gates all state.
module multichannel_staticisor #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                        w_CLK,
  input  logic                        w_RST,
  input  logic                        ready,
  input  logic                        w_HA,
  input  logic                        w_CAPTURE,
  input  logic                        w_MODE,
  input  logic [SEL_W-1:0]            b_CH_sel,
  input  logic                        w_SER_in,
  input  logic [0:WIDTH-1]            b_PAR_in,
  output logic [0:CHANNELS*WIDTH-1]   b_STAT_out,
  output logic [0:CHANNELS-1]         w_VALID,
  output logic                        w_DONE,
  output logic                        w_ERR
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [0:WIDTH-1]    stage [CHANNELS];
  logic [0:CHANNELS-1] pend;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    ch_q;
  logic                mode_q;

  logic             cap, pres, sel_ok, ser_cap, par_cap, partial;
  logic             ser_switch, discard, ser_last;
  logic [CNT_W-1:0] eff_cnt;
  logic [SEL_W-1:0] eff_ch;

  always_comb begin
    cap        = ready & ~w_HA & w_CAPTURE;
    pres       = ready & w_HA;
    sel_ok     = int'(b_CH_sel) < CHANNELS;
    ser_cap    = cap & w_MODE & sel_ok;
    par_cap    = cap & ~w_MODE & sel_ok;
    partial    = (cnt != '0);
    // A serial bit aimed at another channel abandons the partial word and restarts at bit 0.
    ser_switch = ser_cap & partial & (b_CH_sel != ch_q);
    discard    = partial & (pres | (par_cap & mode_q) | ser_switch);
    eff_cnt    = ser_switch ? '0 : cnt;
    eff_ch     = (eff_cnt == '0) ? b_CH_sel : ch_q;
    ser_last   = (eff_cnt == LAST);
  end

  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      for (int c = 0; c < CHANNELS; c++) stage[c] <= '0;
      pend       <= '0;
      cnt        <= '0;
      ch_q       <= '0;
      mode_q     <= 1'b0;
      b_STAT_out <= '0;
      w_VALID    <= '0;
      w_DONE     <= 1'b0;
      w_ERR      <= 1'b0;
    end else begin
      w_DONE <= 1'b0;
      w_ERR  <= 1'b0;
      if (ready) begin
        w_ERR <= discard;
        if (pres) begin
          cnt    <= '0;
          w_DONE <= |pend;
          for (int c = 0; c < CHANNELS; c++) begin
            if (pend[c]) begin
              b_STAT_out[c*WIDTH +: WIDTH] <= stage[c];
              w_VALID[c]                   <= 1'b1;
              pend[c]                      <= 1'b0;
            end
          end
        end else if (par_cap) begin
          stage[b_CH_sel] <= b_PAR_in;
          pend[b_CH_sel]  <= 1'b1;
          cnt             <= '0;
        end else if (ser_cap) begin
          stage[eff_ch][eff_cnt] <= w_SER_in;
          if (eff_cnt == '0) begin
            ch_q   <= b_CH_sel;
            mode_q <= w_MODE;
          end
          if (ser_last) begin
            cnt          <= '0;
            pend[eff_ch] <= 1'b1;
          end else begin
            cnt <= eff_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multichannel_staticisor.sv
// Directed bench for multichannel_staticisor with WIDTH=10, CHANNELS=2; port index k carries weight 2^k.
module tb_multichannel_staticisor;

  localparam int W = 10;

  logic           w_CLK, w_RST, ready, w_HA, w_CAPTURE, w_MODE;
  logic [0:0]     b_CH_sel;
  logic           w_SER_in;
  logic [0:W-1]   b_PAR_in;
  logic [0:2*W-1] b_STAT_out;
  logic [0:1]     w_VALID;
  logic           w_DONE, w_ERR;

  int n_checks = 0;
  int n_errors = 0;

  multichannel_staticisor #(.WIDTH(W), .CHANNELS(2), .SEL_W(1)) dut (
    .w_CLK(w_CLK), .w_RST(w_RST), .ready(ready), .w_HA(w_HA),
    .w_CAPTURE(w_CAPTURE), .w_MODE(w_MODE), .b_CH_sel(b_CH_sel),
    .w_SER_in(w_SER_in), .b_PAR_in(b_PAR_in), .b_STAT_out(b_STAT_out),
    .w_VALID(w_VALID), .w_DONE(w_DONE), .w_ERR(w_ERR)
  );

  initial begin
    w_CLK = 1'b0;
    forever #5 w_CLK = ~w_CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:W-1] to_port(input logic [W-1:0] v);
    logic [0:W-1] p;
    for (int k = 0; k < W; k++) p[k] = v[k];
    return p;
  endfunction

  function automatic logic [W-1:0] slice(input int c);
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) v[k] = b_STAT_out[c*W + k];
    return v;
  endfunction

  function automatic logic [1:0] vld();
    return {w_VALID[1], w_VALID[0]};
  endfunction

  task automatic tick();
    @(posedge w_CLK);
    #1;
  endtask

  task automatic idle();
    ready = 1'b1; w_HA = 1'b0; w_CAPTURE = 1'b0;
    tick();
  endtask

  task automatic ser_bit(input logic ch, input logic b);
    ready = 1'b1; w_HA = 1'b0; w_CAPTURE = 1'b1; w_MODE = 1'b1;
    b_CH_sel = ch; w_SER_in = b;
    tick();
    w_CAPTURE = 1'b0;
  endtask

  task automatic ser_word(input logic ch, input logic [W-1:0] v, input int n);
    for (int k = 0; k < n; k++) ser_bit(ch, v[k]);
  endtask

  task automatic par(input logic ch, input logic [W-1:0] v);
    ready = 1'b1; w_HA = 1'b0; w_CAPTURE = 1'b1; w_MODE = 1'b0;
    b_CH_sel = ch; b_PAR_in = to_port(v);
    tick();
    w_CAPTURE = 1'b0;
  endtask

  task automatic present();
    ready = 1'b1; w_HA = 1'b1; w_CAPTURE = 1'b0;
    tick();
    w_HA = 1'b0;
  endtask

  initial begin
    w_RST = 1'b1; ready = 1'b0; w_HA = 1'b0; w_CAPTURE = 1'b0; w_MODE = 1'b0;
    b_CH_sel = 1'b0; w_SER_in = 1'b0; b_PAR_in = '0;
    #12;
    check("rst_stat", {12'd0, b_STAT_out}, 32'd0);
    check("rst_valid", {30'd0, vld()}, 32'd0);
    check("rst_done", {31'd0, w_DONE}, 32'd0);
    check("rst_err", {31'd0, w_ERR}, 32'd0);
    @(posedge w_CLK); #1;
    w_RST = 1'b0;
    idle();

    // Serial word on ch1
    ser_word(1'b1, 10'h2A5, W);
    check("ser1_before_present", {22'd0, slice(1)}, 32'd0);
    check("ser1_no_err", {31'd0, w_ERR}, 32'd0);
    present();
    check("ser1_slice1", {22'd0, slice(1)}, 32'h2A5);
    check("ser1_slice0", {22'd0, slice(0)}, 32'h000);
    check("ser1_valid", {30'd0, vld()}, 32'h2);
    check("ser1_done", {31'd0, w_DONE}, 32'd1);
    idle();
    check("ser1_done_clear", {31'd0, w_DONE}, 32'd0);
    present();
    check("re_present_done", {31'd0, w_DONE}, 32'd0);

    // Parallel loads on consecutive cycles, single present
    par(1'b0, 10'h3FF);
    par(1'b1, 10'h001);
    check("par_hold_slice1", {22'd0, slice(1)}, 32'h2A5);
    present();
    check("par_slice0", {22'd0, slice(0)}, 32'h3FF);
    check("par_slice1", {22'd0, slice(1)}, 32'h001);
    check("par_valid", {30'd0, vld()}, 32'h3);
    check("par_done", {31'd0, w_DONE}, 32'd1);

    // Channel switch mid serial word
    ser_word(1'b0, 10'h0AA, 5);
    ser_bit(1'b1, 1'b1);
    check("switch_err", {31'd0, w_ERR}, 32'd1);
    ser_bit(1'b1, 1'b1);
    check("switch_err_clear", {31'd0, w_ERR}, 32'd0);
    for (int k = 2; k < W; k++) begin
      logic [W-1:0] v;
      v = 10'h1C3;
      ser_bit(1'b1, v[k]);
    end
    present();
    check("switch_slice1", {22'd0, slice(1)}, 32'h1C3);
    check("switch_slice0", {22'd0, slice(0)}, 32'h3FF);
    check("switch_done", {31'd0, w_DONE}, 32'd1);
    par(1'b0, 10'h000);
    check("wrap_no_err", {31'd0, w_ERR}, 32'd0);
    present();
    check("zero_slice0", {22'd0, slice(0)}, 32'h000);

    // ready=0 freezes everything
    par(1'b1, 10'h0F0);
    ready = 1'b0;
    w_HA = 1'b1; w_CAPTURE = 1'b1; tick();
    w_HA = 1'b0; w_CAPTURE = 1'b1; w_MODE = 1'b1; b_CH_sel = 1'b0; w_SER_in = 1'b1; tick();
    w_MODE = 1'b0; b_CH_sel = 1'b1; b_PAR_in = to_port(10'h3C3); tick();
    w_HA = 1'b1; w_CAPTURE = 1'b0; tick();
    check("frz_slice1", {22'd0, slice(1)}, 32'h1C3);
    check("frz_slice0", {22'd0, slice(0)}, 32'h000);
    check("frz_done", {31'd0, w_DONE}, 32'd0);
    present();
    check("unfrz_slice1", {22'd0, slice(1)}, 32'h0F0);
    check("unfrz_done", {31'd0, w_DONE}, 32'd1);
    check("unfrz_err", {31'd0, w_ERR}, 32'd0);
    ready = 1'b1; w_HA = 1'b1; w_CAPTURE = 1'b1; w_MODE = 1'b0;
    b_CH_sel = 1'b0; b_PAR_in = to_port(10'h111);
    tick();
    check("ha_cap_done", {31'd0, w_DONE}, 32'd0);
    check("ha_cap_slice0", {22'd0, slice(0)}, 32'h000);
    present();
    check("ha_cap_ignored", {31'd0, w_DONE}, 32'd0);

    // Present with partial word (7 bits)
    ser_word(1'b0, 10'h07F, 7);
    present();
    check("partial_err", {31'd0, w_ERR}, 32'd1);
    check("partial_done", {31'd0, w_DONE}, 32'd0);
    check("partial_slice0", {22'd0, slice(0)}, 32'h000);
    ser_bit(1'b0, 1'b1);
    check("partial_err_clear", {31'd0, w_ERR}, 32'd0);
    for (int k = 1; k < W; k++) begin
      logic [W-1:0] v;
      v = 10'h2C9;
      ser_bit(1'b0, v[k]);
    end
    present();
    check("restart_slice0", {22'd0, slice(0)}, 32'h2C9);
    check("restart_done", {31'd0, w_DONE}, 32'd1);

    // Async reset mid serial word
    ser_word(1'b0, 10'h2A5, 4);
    #2 w_RST = 1'b1;
    #1;
    check("mid_rst_stat", {12'd0, b_STAT_out}, 32'd0);
    check("mid_rst_valid", {30'd0, vld()}, 32'd0);
    check("mid_rst_err", {31'd0, w_ERR}, 32'd0);
    @(posedge w_CLK); #1;
    w_RST = 1'b0;
    idle();
    check("post_rst_err", {31'd0, w_ERR}, 32'd0);
    ser_word(1'b0, 10'h155, W);
    present();
    check("post_rst_slice0", {22'd0, slice(0)}, 32'h155);
    check("post_rst_slice1", {22'd0, slice(1)}, 32'h000);
    check("post_rst_valid", {30'd0, vld()}, 32'h1);
    check("post_rst_done", {31'd0, w_DONE}, 32'd1);
    check("post_rst_err2", {31'd0, w_ERR}, 32'd0);
    idle();
    check("post_rst_done_clear", {31'd0, w_DONE}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multichannel_staticisor.md
Name: multichannel_staticisor

Overview:
Parametrised successor to the single-word staticisor. It holds CHANNELS independent staticised words of WIDTH bits. Each word is loaded either bit-serially, least significant bit first from the dynamic store stream, or as a full parallel word. Staged words are presented on their outputs during the w_HA phase, with per-channel valid flags and error reporting, giving the control and arithmetic sections a clean multi-word static interface.

Parameters:
WIDTH, 10, bits per staticised word.
CHANNELS, 2, number of independent words.
SEL_W, 1, width of channel select; must satisfy 2^SEL_W >= CHANNELS.

Ports:
w_CLK  in  1  system clock; all state changes on rising edge.
w_RST  in  1  reset, asynchronous, active-high; clears all state.
ready  in  1  clock enable; no state changes when 0, except reset and the w_DONE/w_ERR clear.
w_HA  in  1  phase: 0 = capture phase, 1 = present phase.
w_CAPTURE  in  1  capture enable, honoured only when w_HA=0.
w_MODE  in  1  0 = parallel load, 1 = serial load.
b_CH_sel  in  SEL_W  target channel for capture.
w_SER_in  in  1  serial data bit.
b_PAR_in  in  [0:WIDTH-1]  parallel data word.
b_STAT_out  out  [0:CHANNELS*WIDTH-1]  presented words; channel c occupies bits c*WIDTH .. c*WIDTH+WIDTH-1.
w_VALID  out  [0:CHANNELS-1]  channel c has been presented at least once since reset.
w_DONE  out  1  one-cycle pulse, high in the cycle after any transfer to the outputs.
w_ERR  out  1  one-cycle pulse, high in the cycle after a partial serial word is discarded.

Behaviour:
- Reset (async, w_RST=1):
  - b_STAT_out, w_VALID, w_DONE and w_ERR go to 0.
  - All staging registers and pending flags are cleared.
  - The bit counter goes to 0 and the latched channel/mode go to 0.
  - Reset mid-word discards the partial word with no w_ERR.
- Per channel state: staging register stage[c] (WIDTH bits) and a pending flag pend[c].
- Serial capture (ready=1, w_HA=0, w_CAPTURE=1, w_MODE=1):
  - w_SER_in is written to stage[ch][cnt].
  - On cnt=0, the current b_CH_sel and mode are latched as ch and mode.
  - cnt then increments.
  - When cnt=WIDTH-1 is written: cnt wraps to 0 and pend[ch] is set.
- Parallel capture (ready=1, w_HA=0, w_CAPTURE=1, w_MODE=0):
  - stage[b_CH_sel] <= b_PAR_in and pend[b_CH_sel] is set, in the same edge.
  - If cnt != 0, the partial serial word is discarded, cnt goes to 0 and w_ERR pulses.
- Discard on cnt != 0 (partial serial word): cnt goes to 0 and w_ERR pulses, in any of these cases:
  - A serial capture arrives with b_CH_sel != latched ch. The current bit then starts a new word at cnt=0 on the new channel, so cnt becomes 1.
  - A serial capture arrives with w_MODE changed to 0; this is the parallel case above.
  - A present phase (ready=1, w_HA=1) arrives.
- Capture cycles with w_CAPTURE=0 hold cnt; gaps inside a serial word are allowed.
- Present (ready=1, w_HA=1), for every channel c with pend[c]=1:
  - The output slice c <= stage[c], w_VALID[c] <= 1 and pend[c] <= 0.
  - Channels without pend hold their outputs.
  - w_DONE is 1 in the next cycle if any channel transferred.
- w_HA=1 together with w_CAPTURE: the capture is ignored (present has priority).
- Latency:
  - Parallel word to output: 1 capture edge plus 1 present edge, visible after the present edge.
  - Serial word: WIDTH capture edges plus 1 present edge.
- Staging registers hold their value after transfer. A later capture overwrites stage; re-presenting without a new capture does nothing, since pend=0.
- b_CH_sel >= CHANNELS: the capture is ignored, with no error.
- w_DONE and w_ERR are registered pulses. They clear in the following cycle regardless of ready.

Test Plan:
- Reset mid-serial: load 4 of 10 bits, assert w_RST -> all outputs 0, w_ERR stays 0; next full word loads cleanly from bit 0.
- Serial load ch1 with word 0x2A5 LSB-first over 10 ready cycles, then w_HA=1 for one cycle -> output slice 1 = 0x2A5, w_VALID=2'b10, w_DONE pulses once, slice 0 stays 0.
- Parallel load ch0=0x3FF and ch1=0x001 in consecutive capture cycles, single present edge -> both slices update on the same edge, w_VALID=2'b11.
- Serial 5 bits to ch0, then switch b_CH_sel to 1 and continue -> w_ERR pulses one cycle, ch0 pend stays 0, ch1 word completes after 10 more bits, cnt wraps to 0.
- ready=0 with toggling w_HA, w_CAPTURE and data -> no change to outputs, cnt or pend; w_HA=1 with w_CAPTURE=1 and no pending channel -> outputs unchanged, w_DONE=0.
- Present with partial serial word (cnt=7) -> w_ERR pulses, outputs unchanged, subsequent serial word starts at bit 0.
